// File: rtl/hwpe_stream_vec_alu.sv
// N-operand vector ALU: joins NB_OPERANDS streams, applies a latched op through an elastic
// pipeline, and runs length-counted jobs. RED_ADD folds all elements into a single result.
module hwpe_stream_vec_alu #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NB_OPERANDS = 2,
    parameter int unsigned PIPE_DEPTH  = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                start_i,
    input  logic [2:0]                          op_i,
    input  logic [CNT_WIDTH-1:0]                len_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [CNT_WIDTH-1:0]                cnt_o,
    input  logic [NB_OPERANDS-1:0]              in_valid_i,
    output logic [NB_OPERANDS-1:0]              in_ready_o,
    input  logic [NB_OPERANDS*DATA_WIDTH-1:0]   in_data_i,
    input  logic [NB_OPERANDS*DATA_WIDTH/8-1:0] in_strb_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic [DATA_WIDTH/8-1:0]             out_strb_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned LAST       = PIPE_DEPTH - 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [2:0] OpAdd    = 3'd0;
    localparam logic [2:0] OpSub    = 3'd1;
    localparam logic [2:0] OpMul    = 3'd2;
    localparam logic [2:0] OpMin    = 3'd3;
    localparam logic [2:0] OpMax    = 3'd4;
    localparam logic [2:0] OpAnd    = 3'd5;
    localparam logic [2:0] OpXor    = 3'd6;
    localparam logic [2:0] OpRedAdd = 3'd7;

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  red_valid_q, red_valid_d;

    logic [PIPE_DEPTH-1:0] pipe_valid_q;
    logic [DATA_WIDTH-1:0] pipe_data_q [PIPE_DEPTH];
    logic [STRB_WIDTH-1:0] pipe_strb_q [PIPE_DEPTH];
    logic [PIPE_DEPTH-1:0] can_acc;

    logic [DATA_WIDTH-1:0] opnd      [NB_OPERANDS];
    logic [STRB_WIDTH-1:0] opnd_strb [NB_OPERANDS];
    logic [DATA_WIDTH-1:0] alu_res;
    logic [STRB_WIDTH-1:0] alu_strb;

    logic red_mode;
    logic join_fire;
    logic last_only;

    assign red_mode = (op_q == OpRedAdd);

    always_comb begin
        for (int k = 0; k < int'(NB_OPERANDS); k++) begin
            opnd[k]      = in_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            opnd_strb[k] = in_strb_i[k*STRB_WIDTH +: STRB_WIDTH];
        end
    end

    always_comb begin
        logic [DATA_WIDTH-1:0] sum_rest;
        logic [DATA_WIDTH-1:0] and_v;
        logic [DATA_WIDTH-1:0] xor_v;
        logic [DATA_WIDTH-1:0] min_v;
        logic [DATA_WIDTH-1:0] max_v;
        sum_rest = '0;
        and_v    = opnd[0];
        xor_v    = opnd[0];
        min_v    = opnd[0];
        max_v    = opnd[0];
        alu_strb = opnd_strb[0];
        for (int k = 1; k < int'(NB_OPERANDS); k++) begin
            sum_rest = sum_rest + opnd[k];
            and_v    = and_v & opnd[k];
            xor_v    = xor_v ^ opnd[k];
            alu_strb = alu_strb & opnd_strb[k];
            if ($signed(opnd[k]) < $signed(min_v)) min_v = opnd[k];
            if ($signed(opnd[k]) > $signed(max_v)) max_v = opnd[k];
        end
        alu_res = '0;
        unique case (op_q)
            OpAdd, OpRedAdd: alu_res = opnd[0] + sum_rest;
            OpSub:           alu_res = opnd[0] - sum_rest;
            OpMul:           alu_res = opnd[0] * opnd[1];
            OpMin:           alu_res = min_v;
            OpMax:           alu_res = max_v;
            OpAnd:           alu_res = and_v;
            OpXor:           alu_res = xor_v;
            default:         alu_res = '0;
        endcase
    end

    // In reduction mode the last stage always drains into the accumulator.
    always_comb begin
        logic down;
        down = red_mode ? 1'b1 : out_ready_i;
        for (int i = int'(LAST); i >= 0; i--) begin
            can_acc[i] = !pipe_valid_q[i] || down;
            down       = can_acc[i];
        end
    end

    assign join_fire  = (state_q == StRun) && (&in_valid_i) && can_acc[0];
    assign in_ready_o = {NB_OPERANDS{join_fire}};

    always_comb begin
        logic [PIPE_DEPTH-1:0] rest;
        rest       = pipe_valid_q;
        rest[LAST] = 1'b0;
        last_only  = pipe_valid_q[LAST] && (rest == '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            pipe_valid_q <= '0;
        end else begin
            if (can_acc[0]) pipe_valid_q[0] <= join_fire;
            for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
                if (can_acc[i]) pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (can_acc[0] && join_fire) begin
            pipe_data_q[0] <= alu_res;
            pipe_strb_q[0] <= alu_strb;
        end
        for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
            if (can_acc[i] && pipe_valid_q[i-1]) begin
                pipe_data_q[i] <= pipe_data_q[i-1];
                pipe_strb_q[i] <= pipe_strb_q[i-1];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        red_valid_d = red_valid_q;

        // All elements are in flight once in DRAIN, so a lone exit is the final one.
        if (red_mode && pipe_valid_q[LAST]) begin
            acc_d = acc_q + pipe_data_q[LAST];
            if (state_q == StDrain && last_only) red_valid_d = 1'b1;
        end
        if (red_valid_q && out_ready_i) red_valid_d = 1'b0;
        if (join_fire && cnt_q != len_q) cnt_d = cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d    = op_i;
                    len_d   = len_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (join_fire && (cnt_q + 1'b1) == len_q) state_d = StDrain;
            end
            StDrain: begin
                if (pipe_valid_q == '0 && !red_valid_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= StIdle;
            op_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            red_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            red_valid_q <= red_valid_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign cnt_o       = cnt_q;
    assign out_valid_o = red_mode ? red_valid_q : pipe_valid_q[LAST];
    assign out_data_o  = !out_valid_o ? '0 : (red_mode ? acc_q : pipe_data_q[LAST]);
    assign out_strb_o  = !out_valid_o ? '0 : (red_mode ? '1 : pipe_strb_q[LAST]);

endmodule

// File: tb/tb_hwpe_stream_vec_alu.sv
// Directed bench for hwpe_stream_vec_alu: a 2-operand instance for the job/pipeline tests
// and a 3-operand instance for SUB/MIN.
module tb_hwpe_stream_vec_alu;

    logic clk = 1'b0;
    logic rst, clear;
    always #5 clk = ~clk;

    logic        start, busy, done, out_valid, out_ready;
    logic [2:0]  op;
    logic [15:0] len, cnt;
    logic [1:0]  in_valid, in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_strb;
    logic [31:0] out_data;
    logic [3:0]  out_strb;

    logic        start3, busy3, done3, out_valid3, out_ready3;
    logic [2:0]  op3;
    logic [15:0] len3, cnt3;
    logic [2:0]  in_valid3, in_ready3;
    logic [95:0] in_data3;
    logic [11:0] in_strb3;
    logic [31:0] out_data3;
    logic [3:0]  out_strb3;

    hwpe_stream_vec_alu #(
        .DATA_WIDTH(32), .NB_OPERANDS(2), .PIPE_DEPTH(2), .CNT_WIDTH(16)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start), .op_i(op), .len_i(len),
        .busy_o(busy), .done_o(done), .cnt_o(cnt), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .in_strb_i(in_strb),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_strb_o(out_strb)
    );

    hwpe_stream_vec_alu #(
        .DATA_WIDTH(32), .NB_OPERANDS(3), .PIPE_DEPTH(2), .CNT_WIDTH(16)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .start_i(start3), .op_i(op3),
        .len_i(len3), .busy_o(busy3), .done_o(done3), .cnt_o(cnt3), .in_valid_i(in_valid3),
        .in_ready_o(in_ready3), .in_data_i(in_data3), .in_strb_i(in_strb3),
        .out_valid_o(out_valid3), .out_ready_i(out_ready3), .out_data_o(out_data3),
        .out_strb_o(out_strb3)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] a_vec [8];
    logic [31:0] b_vec [8];
    logic [31:0] exp_vec [8];
    logic [3:0]  sa, sb, exp_strb;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Enters and leaves at posedge+1; drives inputs, then samples 1 time unit later.
    task automatic run_job(input logic [2:0] jop, input int n_feed, input int n_exp,
                           input int exp_cnt, input bit do_start, input bit toggle,
                           input int b_delay, input int lat_exp, input bit lat_last);
        int idx = 0, oi = 0, bw = 0, cyc = 0, dones = 0;
        int first_join = -1, last_join = -1, first_out = -1;
        bit prev_stall = 0;
        logic [31:0] prev_data = '0;
        int ic;
        if (do_start) begin
            start = 1'b1; op = jop; len = 16'(n_feed); in_valid = '0;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (cyc < 400 && dones == 0) begin
            ic = (idx < 8) ? idx : 0;
            in_valid[0] = (idx < n_feed);
            in_valid[1] = (idx < n_feed) && (bw >= b_delay);
            in_data     = {b_vec[ic], a_vec[ic]};
            in_strb     = {sb, sa};
            out_ready   = toggle ? ((cyc % 2) == 0) : 1'b1;
            #1;
            check_eq("ready_equal", 32'(in_ready[1]), 32'(in_ready[0]));
            if (in_ready[0] && (&in_valid)) begin
                if (first_join < 0) first_join = cyc;
                last_join = cyc;
                idx++;
                bw = 0;
            end else begin
                bw++;
            end
            if (prev_stall) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                if (out_ready) begin
                    check_eq("out_data", out_data, exp_vec[(oi < 8) ? oi : 0]);
                    check_eq("out_strb", 32'(out_strb), 32'(exp_strb));
                    oi++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) dones++;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid = '0;
        check_eq("done_pulses", 32'(dones), 32'd1);
        check_eq("out_count", 32'(oi), 32'(n_exp));
        check_eq("cnt_final", 32'(cnt), 32'(exp_cnt));
        if (lat_exp >= 0) begin
            check_eq("latency", 32'(first_out - (lat_last ? last_join : first_join)),
                     32'(lat_exp));
        end
    endtask

    task automatic run3(input logic [2:0] jop, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] expv, input string tag);
        int got = 0;
        bit fin = 0;
        bit jn;
        start3 = 1'b1; op3 = jop; len3 = 16'd1;
        @(posedge clk); #1;
        start3 = 1'b0; in_valid3 = 3'b111; in_data3 = {c, b, a}; out_ready3 = 1'b1;
        for (int i = 0; i < 20 && !fin; i++) begin
            #1;
            jn = in_ready3[0];
            if (out_valid3) begin
                check_eq(tag, out_data3, expv);
                got++;
            end
            if (done3) fin = 1;
            @(posedge clk); #1;
            if (jn) in_valid3 = '0;
        end
        check_eq("dut3_outputs", 32'(got), 32'd1);
        check_eq("dut3_done", 32'(fin), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0;
        start = 1'b0; op = '0; len = '0; in_valid = '0; in_data = '0; in_strb = '0;
        out_ready = 1'b0;
        start3 = 1'b0; op3 = '0; len3 = '0; in_valid3 = '0; in_data3 = '0; in_strb3 = '1;
        out_ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 2'b11;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_cnt", 32'(cnt), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_strb", 32'(out_strb), 32'd0);
        in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD with wrap and strobe AND
        a_vec[0] = 1;  a_vec[1] = 2;  a_vec[2] = 3;  a_vec[3] = 32'hFFFF_FFFF;
        b_vec[0] = 10; b_vec[1] = 20; b_vec[2] = 30; b_vec[3] = 2;
        exp_vec[0] = 11; exp_vec[1] = 22; exp_vec[2] = 33; exp_vec[3] = 1;
        sa = 4'hF; sb = 4'h3; exp_strb = 4'h3;
        run_job(3'd0, 4, 4, 4, 1, 0, 0, 2, 0);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // RED_ADD: single output, strobe all ones
        a_vec[0] = 5; a_vec[1] = 6; a_vec[2] = 7;
        b_vec[0] = 1; b_vec[1] = 1; b_vec[2] = 1;
        exp_vec[0] = 21;
        sa = 4'h1; sb = 4'h2; exp_strb = 4'hF;
        run_job(3'd7, 3, 1, 3, 1, 0, 0, 3, 1);

        // MUL (low bits), MAX (signed), AND, XOR
        sa = 4'hF; sb = 4'hF; exp_strb = 4'hF;
        a_vec[0] = 3; a_vec[1] = 32'h0001_0000; b_vec[0] = 7; b_vec[1] = 32'h0001_0000;
        exp_vec[0] = 21; exp_vec[1] = 0;
        run_job(3'd2, 2, 2, 2, 1, 0, 0, 2, 0);
        a_vec[0] = 32'hFFFF_FFFF; a_vec[1] = 5; b_vec[0] = 32'hFFFF_FFF9; b_vec[1] = 2;
        exp_vec[0] = 32'hFFFF_FFFF; exp_vec[1] = 5;
        run_job(3'd4, 2, 2, 2, 1, 0, 0, 2, 0);
        a_vec[0] = 32'h0000_F0F0; b_vec[0] = 32'h0000_FF00;
        exp_vec[0] = 32'h0000_F000;
        run_job(3'd5, 1, 1, 1, 1, 0, 0, 2, 0);
        exp_vec[0] = 32'h0000_0FF0;
        run_job(3'd6, 1, 1, 1, 1, 0, 0, 2, 0);

        // Backpressure: output ready toggles, B valid lags 3 cycles per element
        for (int i = 0; i < 5; i++) begin
            a_vec[i] = 32'(i + 1);
            b_vec[i] = 32'(100 * (i + 1));
            exp_vec[i] = 32'(101 * (i + 1));
        end
        run_job(3'd0, 5, 5, 5, 1, 1, 3, -1, 0);

        // Zero-length job
        start = 1'b1; op = 3'd0; len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 2'b11;
        #1;
        check_eq("len0_busy", 32'(busy), 32'd1);
        check_eq("len0_done", 32'(done), 32'd1);
        check_eq("len0_in_ready", 32'(in_ready), 32'd0);
        check_eq("len0_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = '0;
        check_eq("len0_busy_after", 32'(busy), 32'd0);
        check_eq("len0_done_after", 32'(done), 32'd0);

        // start_i during RUN is ignored
        a_vec[0] = 1; b_vec[0] = 1;
        start = 1'b1; op = 3'd0; len = 16'd3; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 2'b11; in_data = {b_vec[0], a_vec[0]};
        @(posedge clk); #1;
        in_valid = '0; start = 1'b1; op = 3'd6; len = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("run_start_cnt", 32'(cnt), 32'd1);
        check_eq("run_start_busy", 32'(busy), 32'd1);
        a_vec[0] = 2; a_vec[1] = 3; b_vec[0] = 1; b_vec[1] = 1;
        exp_vec[0] = 2; exp_vec[1] = 3; exp_vec[2] = 4;
        run_job(3'd0, 2, 3, 3, 0, 0, 0, -1, 0);

        // clear_i mid-job with two elements in flight and output stalled
        start = 1'b1; op = 3'd0; len = 16'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 2'b11; in_data = {32'd1, 32'd1};
        repeat (2) @(posedge clk);
        #1;
        in_valid = '0;
        #1;
        check_eq("pre_clear_valid", 32'(out_valid), 32'd1);
        check_eq("pre_clear_cnt", 32'(cnt), 32'd2);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check_eq("clear_out_valid", 32'(out_valid), 32'd0);
        check_eq("clear_busy", 32'(busy), 32'd0);
        check_eq("clear_cnt", 32'(cnt), 32'd0);
        check_eq("clear_done", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("clear_no_done", 32'(done), 32'd0);
        end
        a_vec[0] = 4; a_vec[1] = 5; b_vec[0] = 6; b_vec[1] = 7;
        exp_vec[0] = 10; exp_vec[1] = 12;
        run_job(3'd0, 2, 2, 2, 1, 0, 0, 2, 0);

        // Three-operand SUB and signed MIN
        run3(3'd1, 32'd100, 32'd30, 32'd80, 32'hFFFF_FFF6, "sub3");
        run3(3'd3, 32'hFFFF_FFFB, 32'd3, 32'd0, 32'hFFFF_FFFB, "min3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_vec_alu.md
Name: hwpe_stream_vec_alu

Overview:
- Parametrised N-operand vector ALU engine. Sits between the operand stream sources and the result stream sink in the HWPE datapath.
- Joins NB_OPERANDS input streams element by element and applies a selectable operation through an elastic pipeline of configurable depth.
- Runs a length-counted job with start/busy/done control.
- Supports element-wise modes and a reduction mode that emits a single result per job.

Parameters:
- DATA_WIDTH, 32: element width in bits; multiple of 8.
- NB_OPERANDS, 2: number of input streams, legal range 2..4.
- PIPE_DEPTH, 2: register stages between join and output, legal range 1..4.
- CNT_WIDTH, 16: width of the job length and element counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- clear_i  in  1  synchronous soft clear.
- start_i  in  1  start job; accepted in IDLE only.
- op_i  in  3  operation code; latched on start.
- len_i  in  CNT_WIDTH  number of elements per stream; latched on start.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle job completion pulse.
- cnt_o  out  CNT_WIDTH  input elements joined so far in the current job.
- in_valid_i  in  NB_OPERANDS  per-stream valid.
- in_ready_o  out  NB_OPERANDS  per-stream ready.
- in_data_i  in  NB_OPERANDS*DATA_WIDTH  operand k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_strb_i  in  NB_OPERANDS*DATA_WIDTH/8  per-stream byte strobes.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result ready.
- out_data_o  out  DATA_WIDTH  result data.
- out_strb_o  out  DATA_WIDTH/8  result strobe.

Behaviour:
- Reset (rst_i high at a clock edge): FSM goes to IDLE. All pipeline valids, counter and accumulator clear to 0. All outputs read 0: in_ready_o, out_valid_o, busy_o, done_o, cnt_o, out_data_o, out_strb_o.
- clear_i: identical effect to rst_i. Takes priority over every other event, including mid-job, with a stalled output, or coincident with start_i. No done_o pulse is produced.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start_i with len_i>0 moves to RUN; start_i with len_i=0 moves to DONE. Both latch op_i and len_i and zero cnt_o and the accumulator.
  - RUN: after the join at which cnt reaches len, move to DRAIN.
  - DRAIN: when the pipeline is empty and the final output handshake has completed, move to DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- busy_o=1 in RUN, DRAIN and DONE.
- start_i outside IDLE is ignored; latched op and len are unaffected.
- Join rule:
  - join fires when state==RUN, all in_valid_i are 1, and pipeline stage 0 can accept.
  - in_ready_o[k] = (join condition) for every k, so all streams handshake together.
  - in_ready_o is 0 in IDLE, DRAIN and DONE.
  - in_ready_o may depend combinationally on in_valid_i; in_valid_i must not depend on in_ready_o.
- Pipeline:
  - each stage advances when the downstream stage is empty or advancing.
  - a stall holds all data stable.
  - throughput is 1 element/cycle when out_ready_i is held high.
  - element-wise latency is PIPE_DEPTH cycles from join to out_valid_o.
  - while out_valid_o=1 and out_ready_i=0, out_data_o and out_strb_o stay stable.
- Operations (all arithmetic modulo 2^DATA_WIDTH):
  - 0 ADD: sum of all operands.
  - 1 SUB: op0 minus the sum of the remaining operands.
  - 2 MUL: low DATA_WIDTH bits of op0*op1; other operands ignored.
  - 3 MIN: signed minimum of all operands.
  - 4 MAX: signed maximum of all operands.
  - 5 AND: bitwise AND of all operands.
  - 6 XOR: bitwise XOR of all operands.
  - 7 RED_ADD: see reduction rules below.
- Element-wise strobes: out_strb_o = bitwise AND of all in_strb_i.
- RED_ADD reduction:
  - per-element sums traverse the pipeline; at the pipeline exit they are added into the accumulator.
  - intermediate sums never raise out_valid_o.
  - after the last element exits, out_valid_o rises one cycle later with out_data_o = total, modulo 2^DATA_WIDTH. Latency from the last join is PIPE_DEPTH+1 cycles.
  - out_strb_o is all ones.
- cnt_o increments by 1 on each join and saturates at len. It does not wrap within a job and holds its value until the next start.
- Illegal op codes cannot occur: all 8 codes are defined.

Test Plan:
1. NB_OPERANDS=2, PIPE_DEPTH=2, op=ADD, len=4; A={1,2,3,0xFFFFFFFF}, B={10,20,30,2}; out_ready_i=1 -> outputs {11,22,33,1}; first out_valid_o 2 cycles after the first join; done_o pulses once; cnt_o=4.
2. op=RED_ADD, len=3; A={5,6,7}, B={1,1,1} -> exactly one output, data=21, strb=0xF, 3 cycles after the last join; then done_o.
3. op=SUB with NB_OPERANDS=3; A=100, B=30, C=80 -> out_data_o=0xFFFFFFF6. Then op=MIN with A=-5, B=3, C=0 -> 0xFFFFFFFB.
4. Backpressure: out_ready_i toggling 1010…, B valid delayed 3 cycles per element -> no element lost or duplicated; in_ready_o equal across streams at every cycle; output data stable during stalls.
5. len=0 start -> busy_o=1 for 1 cycle, done_o pulses the next cycle; no in_ready_o and no out_valid_o. A start_i issued in RUN is ignored and cnt_o continues unaffected.
6. clear_i asserted mid-job with 2 elements in flight and out_ready_i=0 -> the next cycle shows out_valid_o=0, busy_o=0, cnt_o=0, and no done_o. A new job then completes correctly.
